// File: rtl/elev_pkg.sv
// ============================================================================
// Module      : elev_pkg
// Description : Shared types and helpers for the elevator car controller:
//               FSM state encoding, travel direction, index-width function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package elev_pkg;

  // Car controller states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    DOOR_OPEN = 3'd3,
    FAULT     = 3'd4
  } state_t;

  // Travel direction remembered between trips.
  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : elev_pkg

`default_nettype wire

// File: rtl/elev_tick_cnt.sv
// ============================================================================
// Module      : elev_tick_cnt
// Description : Loadable down-counter with a zero flag. Holds at zero.
//   clk        in  : clock
//   rst        in  : asynchronous active-high reset (count -> 0)
//   load_i     in  : load load_val_i (wins over en_i)
//   load_val_i in  : WIDTH-bit reload value
//   en_i       in  : decrement by one while non-zero
//   zero_o     out : count is zero
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module elev_tick_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule : elev_tick_cnt

`default_nettype wire

// File: rtl/elev_car_ctrl.sv
// ============================================================================
// Module      : elev_car_ctrl
// Description : Elevator car motion controller. Reads active-low latched
//               hall calls, picks a direction, drives the motor commands,
//               tracks position from floor sensors and dwells the door.
//   clk          in  : system clock
//   rst          in  : asynchronous active-high reset
//   req_n        in  : latched calls, active-low, one bit per floor
//   floor_sensor in  : one-hot when aligned at a floor, else between floors
//   motor_up     out : registered up command
//   motor_down   out : registered down command
//   door_open    out : registered door command
//   cur_floor    out : last floor the car was aligned at
//   fault        out : sticky travel watchdog fault
// Build option: define ELEV_WATCHDOG_EN to build the travel watchdog;
//               otherwise fault is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module elev_car_ctrl
  import elev_pkg::*;
#(
  parameter int FLOORS       = 4,
  parameter int DOOR_TICKS   = 8,
  parameter int TRAVEL_TICKS = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FLOORS-1:0]         req_n,
  input  logic [FLOORS-1:0]         floor_sensor,
  output logic                      motor_up,
  output logic                      motor_down,
  output logic                      door_open,
  output logic [$clog2(FLOORS)-1:0] cur_floor,
  output logic                      fault
);

  localparam int FW = $clog2(FLOORS);
  localparam int DW = idx_width(DOOR_TICKS);
  localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_TICKS - 1);
  localparam logic [FW-1:0] TOP_FLOOR = FW'(FLOORS - 1);

  state_t          state_q, state_d;
  dir_t            last_dir_q, last_dir_d;
  logic            up_q, up_d, dn_q, dn_d, door_q, door_d;
  logic [FW-1:0]   cur_q, cur_d;
  logic            mask_vld_q, mask_vld_d;
  logic [FW-1:0]   mask_idx_q, mask_idx_d;

  logic [FLOORS-1:0] mask_bits, act;
  logic [FW-1:0]     sens_idx;
  logic              sens_vld;
  logic              above, below, here, ahead_up, ahead_dn;
  logic              door_load, door_en, door_zero;

`ifdef ELEV_WATCHDOG_EN
  localparam int TW = idx_width(TRAVEL_TICKS);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_TICKS - 1);
  logic wd_load, wd_en, wd_zero;
`endif

  // Sensor decode and the floor mask as a bit vector.
  always_comb begin
    mask_bits = '0;
    sens_idx  = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (mask_vld_q && (int'(mask_idx_q) == i)) mask_bits[i] = 1'b1;
      if (floor_sensor[i]) sens_idx = FW'(i);
    end
  end

  assign sens_vld = $onehot(floor_sensor);
  assign act      = ~req_n & ~mask_bits;
  assign here     = act[cur_q];

  // above/below relate to the stored floor (IDLE decisions); ahead_* relate
  // to the floor being sensed right now (stop decisions while moving).
  always_comb begin
    above    = 1'b0;
    below    = 1'b0;
    ahead_up = 1'b0;
    ahead_dn = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (act[i]) begin
        if (i > int'(cur_q))    above    = 1'b1;
        if (i < int'(cur_q))    below    = 1'b1;
        if (i > int'(sens_idx)) ahead_up = 1'b1;
        if (i < int'(sens_idx)) ahead_dn = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    up_d       = up_q;
    dn_d       = dn_q;
    door_d     = door_q;
    cur_d      = cur_q;
    mask_vld_d = mask_vld_q;
    mask_idx_d = mask_idx_q;
    door_load  = 1'b0;
    door_en    = 1'b0;

    case (state_q)
      IDLE: begin
        up_d   = 1'b0;
        dn_d   = 1'b0;
        door_d = 1'b0;
        if (here) begin
          state_d   = DOOR_OPEN;
          door_d    = 1'b1;
          door_load = 1'b1;
        end else if (above && (!below || (last_dir_q == UP))) begin
          state_d    = MOVE_UP;
          up_d       = 1'b1;
          last_dir_d = UP;
        end else if (below) begin
          state_d    = MOVE_DOWN;
          dn_d       = 1'b1;
          last_dir_d = DOWN;
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        if (sens_vld) begin
          cur_d = sens_idx;
          // Only a different floor releases the mask; the floor just left
          // may still show its own sensor for a moment.
          if (sens_idx != cur_q) mask_vld_d = 1'b0;
          if (act[sens_idx] ||
              ((state_q == MOVE_UP)   && (!ahead_up || (sens_idx == TOP_FLOOR))) ||
              ((state_q == MOVE_DOWN) && (!ahead_dn || (sens_idx == '0)))) begin
            up_d = 1'b0;
            dn_d = 1'b0;
            if (act[sens_idx]) begin
              state_d   = DOOR_OPEN;
              door_d    = 1'b1;
              door_load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
`ifdef ELEV_WATCHDOG_EN
        else if (wd_zero) begin
          state_d = FAULT;
          up_d    = 1'b0;
          dn_d    = 1'b0;
        end
`endif
      end

      DOOR_OPEN: begin
        if (door_zero) begin
          door_d     = 1'b0;
          mask_vld_d = 1'b1;
          mask_idx_d = cur_q;
          state_d    = IDLE;
        end else begin
          door_en = 1'b1;
        end
      end

      FAULT: begin
        up_d   = 1'b0;
        dn_d   = 1'b0;
        door_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        door_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_dir_q <= UP;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
      door_q     <= 1'b0;
      cur_q      <= '0;
      mask_vld_q <= 1'b0;
      mask_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      up_q       <= up_d;
      dn_q       <= dn_d;
      door_q     <= door_d;
      cur_q      <= cur_d;
      mask_vld_q <= mask_vld_d;
      mask_idx_q <= mask_idx_d;
    end
  end

  elev_tick_cnt #(.WIDTH(DW)) u_door_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (door_load),
    .load_val_i (DOOR_LOAD),
    .en_i       (door_en),
    .zero_o     (door_zero)
  );

`ifdef ELEV_WATCHDOG_EN
  // Restart on trip start and on every valid sensor while moving.
  assign wd_en   = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
  assign wd_load = ((state_q == IDLE) && ((state_d == MOVE_UP) || (state_d == MOVE_DOWN))) ||
                   (wd_en && sens_vld);

  elev_tick_cnt #(.WIDTH(TW)) u_wd_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wd_load),
    .load_val_i (TRAVEL_LOAD),
    .en_i       (wd_en),
    .zero_o     (wd_zero)
  );

  assign fault = (state_q == FAULT);
`else
  assign fault = 1'b0;
`endif

  assign motor_up   = up_q;
  assign motor_down = dn_q;
  assign door_open  = door_q;
  assign cur_floor  = cur_q;

endmodule : elev_car_ctrl

`default_nettype wire

// File: tb/tb_elev_car_ctrl.sv
// ============================================================================
// Module      : tb_elev_car_ctrl
// Description : Self-checking bench for elev_car_ctrl: directed scenarios
//               plus randomized traffic against a simple building model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_elev_car_ctrl;

  localparam int F  = 4;
  localparam int DT = 8;
  localparam int TT = 16;
  localparam int K  = 4;   // model cycles of travel between adjacent floors

  logic         clk = 1'b0;
  logic         rst;
  logic [F-1:0] req_n;
  logic [F-1:0] floor_sensor;
  logic         motor_up, motor_down, door_open, fault;
  logic [1:0]   cur_floor;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  elev_car_ctrl #(.FLOORS(F), .DOOR_TICKS(DT), .TRAVEL_TICKS(TT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_n        (req_n),
    .floor_sensor (floor_sensor),
    .motor_up     (motor_up),
    .motor_down   (motor_down),
    .door_open    (door_open),
    .cur_floor    (cur_floor),
    .fault        (fault)
  );

  function automatic int oh_idx(input logic [F-1:0] v);
    int r = 0;
    for (int i = 0; i < F; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req_n = '1; floor_sensor = 4'b0001;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({motor_up, motor_down, door_open, fault} !== 4'b0 || cur_floor !== 2'd0) begin
      bad++; $display("FAIL reset_state: got up=%b dn=%b door=%b flt=%b cur=%0d, want all 0",
                      motor_up, motor_down, door_open, fault, cur_floor);
    end
    // Start a trip, pass floor 1, then reset asynchronously mid-move.
    req_n = 4'b0111;
    @(negedge clk);
    floor_sensor = 4'b0000;
    @(negedge clk);
    floor_sensor = 4'b0010;
    @(negedge clk);
    total++;
    if (motor_up !== 1'b1 || cur_floor !== 2'd1) begin
      bad++; $display("FAIL reset_premove: got up=%b cur=%0d, want up=1 cur=1", motor_up, cur_floor);
    end
    floor_sensor = 4'b0000;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({motor_up, motor_down, door_open, fault} !== 4'b0 || cur_floor !== 2'd0) begin
      bad++; $display("FAIL reset_async: got up=%b dn=%b door=%b flt=%b cur=%0d, want all 0",
                      motor_up, motor_down, door_open, fault, cur_floor);
    end
    req_n = '1; floor_sensor = 4'b0001;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_call_up();
    int n;
    req_n = 4'b0111;
    @(negedge clk);
    total++;
    if (motor_up !== 1'b1 || motor_down !== 1'b0 || door_open !== 1'b0) begin
      bad++; $display("FAIL call_up_start: got up=%b dn=%b door=%b, want 1 0 0", motor_up, motor_down, door_open);
    end
    floor_sensor = 4'b0000; @(negedge clk);
    floor_sensor = 4'b0010; @(negedge clk);
    total++;
    if (cur_floor !== 2'd1 || motor_up !== 1'b1) begin
      bad++; $display("FAIL call_up_pass1: got cur=%0d up=%b, want 1 1", cur_floor, motor_up);
    end
    floor_sensor = 4'b0000; @(negedge clk);
    floor_sensor = 4'b0100; @(negedge clk);
    total++;
    if (cur_floor !== 2'd2 || motor_up !== 1'b1) begin
      bad++; $display("FAIL call_up_pass2: got cur=%0d up=%b, want 2 1", cur_floor, motor_up);
    end
    floor_sensor = 4'b0000; @(negedge clk);
    floor_sensor = 4'b1000; @(negedge clk);
    total++;
    if (motor_up !== 1'b0 || cur_floor !== 2'd3 || door_open !== 1'b1) begin
      bad++; $display("FAIL call_up_arrive: got up=%b cur=%0d door=%b, want 0 3 1", motor_up, cur_floor, door_open);
    end
    req_n = '1;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (door_open) n++; else break;
    end
    total++;
    if (n !== DT || motor_up !== 1'b0 || motor_down !== 1'b0) begin
      bad++; $display("FAIL door_dwell: got %0d cycles up=%b dn=%b, want %0d 0 0", n, motor_up, motor_down, DT);
    end
  endtask

  task automatic test_here_mask();
    int n;
    bit ok;
    // From floor 3 head for 0, withdraw the call, stop idle at floor 2.
    req_n = 4'b1110;
    @(negedge clk);
    total++;
    if (motor_down !== 1'b1) begin
      bad++; $display("FAIL here_depart: got dn=%b, want 1", motor_down);
    end
    req_n = '1; floor_sensor = 4'b0000;
    @(negedge clk);
    floor_sensor = 4'b0100;
    @(negedge clk);
    total++;
    if (motor_up !== 1'b0 || motor_down !== 1'b0 || door_open !== 1'b0 || cur_floor !== 2'd2) begin
      bad++; $display("FAIL noahead_stop: got up=%b dn=%b door=%b cur=%0d, want 0 0 0 2",
                      motor_up, motor_down, door_open, cur_floor);
    end
    req_n = 4'b1011;
    @(negedge clk);
    total++;
    if (door_open !== 1'b1 || motor_up !== 1'b0 || motor_down !== 1'b0) begin
      bad++; $display("FAIL here_open: got door=%b up=%b dn=%b, want 1 0 0", door_open, motor_up, motor_down);
    end
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (door_open) n++; else break;
    end
    total++;
    if (n !== DT) begin
      bad++; $display("FAIL here_dwell: got %0d cycles, want %0d", n, DT);
    end
    ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (door_open || motor_up || motor_down) ok = 1'b0;
    end
    total++;
    if (ok !== 1'b1) begin
      bad++; $display("FAIL here_masked: got reopen/move while masked, want door and motors idle");
    end
    req_n = '1;
    @(negedge clk);
  endtask

  task automatic test_direction_priority();
    int n;
    // Down to floor 0, then up to floor 1 so last_dir=UP at floor 1.
    req_n = 4'b1110;
    @(negedge clk); floor_sensor = 4'b0000;
    @(negedge clk); floor_sensor = 4'b0010;
    @(negedge clk); floor_sensor = 4'b0000;
    @(negedge clk); floor_sensor = 4'b0001;
    @(negedge clk);
    req_n = '1;
    for (int i = 0; i < 20 && door_open; i++) @(negedge clk);
    req_n = 4'b1101;
    @(negedge clk); floor_sensor = 4'b0000;
    @(negedge clk); floor_sensor = 4'b0010;
    @(negedge clk);
    total++;
    if (door_open !== 1'b1 || cur_floor !== 2'd1) begin
      bad++; $display("FAIL setup_floor1: got door=%b cur=%0d, want 1 1", door_open, cur_floor);
    end
    req_n = '1;
    for (int i = 0; i < 20 && door_open; i++) @(negedge clk);
    // Calls at 0 and 3 with last_dir=UP.
    req_n = 4'b0110;
    @(negedge clk);
    total++;
    if (motor_up !== 1'b1 || motor_down !== 1'b0) begin
      bad++; $display("FAIL prio_up: got up=%b dn=%b, want 1 0", motor_up, motor_down);
    end
    floor_sensor = 4'b0000; @(negedge clk);
    floor_sensor = 4'b0100; @(negedge clk);
    floor_sensor = 4'b0000; @(negedge clk);
    floor_sensor = 4'b1000; @(negedge clk);
    total++;
    if (door_open !== 1'b1 || cur_floor !== 2'd3 || motor_up !== 1'b0) begin
      bad++; $display("FAIL prio_top: got door=%b cur=%0d up=%b, want 1 3 0", door_open, cur_floor, motor_up);
    end
    req_n = 4'b1110;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (door_open) n++; else break;
    end
    @(negedge clk);
    total++;
    if (n !== DT || motor_down !== 1'b1) begin
      bad++; $display("FAIL prio_reverse: got dwell=%0d dn=%b, want %0d 1", n, motor_down, DT);
    end
    // Non-one-hot pattern must be ignored.
    floor_sensor = 4'b0000; @(negedge clk);
    floor_sensor = 4'b0110; @(negedge clk);
    total++;
    if (cur_floor !== 2'd3 || motor_down !== 1'b1) begin
      bad++; $display("FAIL glitch_ignored: got cur=%0d dn=%b, want 3 1", cur_floor, motor_down);
    end
    floor_sensor = 4'b0010; @(negedge clk);
    total++;
    if (cur_floor !== 2'd1 || motor_down !== 1'b1) begin
      bad++; $display("FAIL glitch_then_valid: got cur=%0d dn=%b, want 1 1", cur_floor, motor_down);
    end
    floor_sensor = 4'b0000; @(negedge clk);
    floor_sensor = 4'b0001; @(negedge clk);
    total++;
    if (door_open !== 1'b1 || cur_floor !== 2'd0 || motor_down !== 1'b0) begin
      bad++; $display("FAIL prio_bottom: got door=%b cur=%0d dn=%b, want 1 0 0", door_open, cur_floor, motor_down);
    end
    req_n = '1;
    for (int i = 0; i < 20 && door_open; i++) @(negedge clk);
    total++;
    if (door_open !== 1'b0) begin
      bad++; $display("FAIL prio_close: got door=%b, want 0", door_open);
    end
  endtask

  task automatic test_watchdog();
    req_n = 4'b0111;
    @(negedge clk);
    floor_sensor = 4'b0000;
`ifdef ELEV_WATCHDOG_EN
    begin
      int hi;
      hi = motor_up ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (fault) break;
        if (motor_up) hi++;
      end
      total++;
      if (hi !== TT || fault !== 1'b1 || motor_up !== 1'b0 || motor_down !== 1'b0 || door_open !== 1'b0) begin
        bad++; $display("FAIL watchdog_trip: got hi=%0d flt=%b up=%b dn=%b door=%b, want %0d 1 0 0 0",
                        hi, fault, motor_up, motor_down, door_open, TT);
      end
      req_n = '1;
      repeat (5) @(negedge clk);
      total++;
      if (fault !== 1'b1) begin
        bad++; $display("FAIL watchdog_sticky: got flt=%b, want 1", fault);
      end
    end
`else
    repeat (40) @(negedge clk);
    total++;
    if (fault !== 1'b0 || motor_up !== 1'b1) begin
      bad++; $display("FAIL no_watchdog: got flt=%b up=%b, want 0 1", fault, motor_up);
    end
`endif
    #2 rst = 1'b1;
    #1;
    total++;
    if (fault !== 1'b0 || motor_up !== 1'b0) begin
      bad++; $display("FAIL watchdog_reset: got flt=%b up=%b, want 0 0", fault, motor_up);
    end
    req_n = '1; floor_sensor = 4'b0001;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Randomized traffic: a building model moves the car one position step per
  // motor cycle, shows sensors (with random between-floor glitches), latches
  // random calls and clears them when the door opens. Each cycle the outputs
  // are judged against the dispatch rules applied to what the car saw.
  task automatic test_random_traffic();
    int pos, ecur, door_run, f, g;
    bit ldir_up, ahead, stop, above, below, exp_up, exp_dn;
    logic [F-1:0] req, sens, p_req, p_sens, one;
    logic p_up, p_dn, p_door;
    one = 1;
    rst = 1'b1; req_n = '1; floor_sensor = 4'b0001;
    @(negedge clk);
    rst = 1'b0;
    pos = 0; ecur = 0; door_run = 0; ldir_up = 1'b1;
    req = '0; p_req = '0; p_sens = 4'b0001;
    p_up = 1'b0; p_dn = 1'b0; p_door = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      total++;
      if ((motor_up && motor_down) || (door_open && (motor_up || motor_down))) begin
        bad++; $display("FAIL rnd_invariant: cyc=%0d up=%b dn=%b door=%b", cyc, motor_up, motor_down, door_open);
      end
      if ((p_up || p_dn) && $onehot(p_sens)) begin
        f = oh_idx(p_sens);
        ahead = 1'b0;
        for (int i = 0; i < F; i++) if (p_req[i] && (p_up ? (i > f) : (i < f))) ahead = 1'b1;
        stop = p_req[f] || !ahead || (p_up ? (f == F-1) : (f == 0));
        ecur = f;
        total++;
        if (stop && (motor_up !== 1'b0 || motor_down !== 1'b0 || door_open !== p_req[f])) begin
          bad++; $display("FAIL rnd_stop: cyc=%0d floor=%0d got up=%b dn=%b door=%b, want 0 0 %b",
                          cyc, f, motor_up, motor_down, door_open, p_req[f]);
        end else if (!stop && (motor_up !== p_up || motor_down !== p_dn || door_open !== 1'b0)) begin
          bad++; $display("FAIL rnd_pass: cyc=%0d floor=%0d got up=%b dn=%b door=%b, want %b %b 0",
                          cyc, f, motor_up, motor_down, door_open, p_up, p_dn);
        end
      end else if (p_up || p_dn) begin
        total++;
        if (motor_up !== p_up || motor_down !== p_dn || door_open !== 1'b0) begin
          bad++; $display("FAIL rnd_travel: cyc=%0d got up=%b dn=%b door=%b, want %b %b 0",
                          cyc, motor_up, motor_down, door_open, p_up, p_dn);
        end
      end else if (!p_door) begin
        above = 1'b0; below = 1'b0;
        for (int i = 0; i < F; i++) begin
          if (p_req[i] && i > ecur) above = 1'b1;
          if (p_req[i] && i < ecur) below = 1'b1;
        end
        exp_up = above && (!below || ldir_up);
        exp_dn = below && !exp_up;
        total++;
        if (motor_up !== exp_up || motor_down !== exp_dn || door_open !== 1'b0) begin
          bad++; $display("FAIL rnd_dispatch: cyc=%0d cur=%0d req=%b got up=%b dn=%b door=%b, want %b %b 0",
                          cyc, ecur, p_req, motor_up, motor_down, door_open, exp_up, exp_dn);
        end
      end
      total++;
      if (cur_floor !== ecur || fault !== 1'b0) begin
        bad++; $display("FAIL rnd_floor: cyc=%0d got cur=%0d flt=%b, want %0d 0", cyc, cur_floor, fault, ecur);
      end
      if (door_open) begin
        door_run++;
      end else if (door_run > 0) begin
        total++;
        if (door_run !== DT) begin
          bad++; $display("FAIL rnd_dwell: cyc=%0d got %0d cycles, want %0d", cyc, door_run, DT);
        end
        door_run = 0;
      end
      if (motor_up) ldir_up = 1'b1;
      else if (motor_down) ldir_up = 1'b0;
      if (door_open) req[ecur] = 1'b0;
      if (cyc < 2400 && $urandom_range(0, 5) == 0) begin
        g = $urandom_range(0, F-1);
        if (g != ecur) req[g] = 1'b1;
      end
      if (motor_up) pos++;
      else if (motor_down) pos--;
      if (pos < 0) pos = 0;
      if (pos > (F-1)*K) pos = (F-1)*K;
      if (pos % K == 0) sens = one << (pos / K);
      else if ($urandom_range(0, 3) == 0) sens = (one | (one << 1)) << (pos / K);
      else sens = '0;
      p_up = motor_up; p_dn = motor_down; p_door = door_open;
      p_req = req; p_sens = sens;
      req_n = ~req; floor_sensor = sens;
    end
    total++;
    if (req !== '0 || motor_up || motor_down || door_open) begin
      bad++; $display("FAIL rnd_drain: got pending=%b up=%b dn=%b door=%b, want all served and idle",
                      req, motor_up, motor_down, door_open);
    end
  endtask

  initial begin
    rst = 1'b1; req_n = '1; floor_sensor = 4'b0001;
    test_reset();
    test_single_call_up();
    test_here_mask();
    test_direction_priority();
    test_watchdog();
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_elev_car_ctrl

`default_nettype wire
